// File: rtl/icache_refill_ctrl_pkg.sv
// icache_refill_ctrl_pkg: shared constants for the I-cache refill path.
// Address split, AXI burst encodings and refill FSM states.
package icache_refill_ctrl_pkg;

  localparam int DEF_BEATS = 4;
  localparam int DEF_WAYS  = 8;
  localparam int DEF_SETS  = 8;

  localparam int BLK_LSB = 4;
  localparam int IDX_LSB = 4;
  localparam int IDX_MSB = 6;
  localparam int TAG_LSB = 7;

  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_DONE
  } refill_state_e;

endpackage

// File: rtl/icache_victim_rr.sv
// icache_victim_rr: per-set round-robin victim way pointers.
// Read by set index; the addressed pointer advances on a performed write.
module icache_victim_rr
  import icache_refill_ctrl_pkg::*;
#(
  parameter int SETS = DEF_SETS,
  parameter int WAYS = DEF_WAYS
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [$clog2(SETS)-1:0]  index_i,
  input  logic                     inc_i,
  output logic [$clog2(WAYS)-1:0]  way_o
);

  localparam int WW = $clog2(WAYS);
  localparam logic [WW-1:0] LAST_WAY = WW'(WAYS - 1);

  logic [WW-1:0] ptr_q [SETS];

  assign way_o = ptr_q[index_i];

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < SETS; i++) begin
        ptr_q[i] <= '0;
      end
    end else if (inc_i) begin
      ptr_q[index_i] <= (ptr_q[index_i] == LAST_WAY) ?
                        '0 : ptr_q[index_i] + 1'b1;
    end
  end

endmodule

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: fetches a missing line over an AXI INCR burst,
// writes it into the victim way and hands the line back to fetch.
module icache_refill_ctrl
  import icache_refill_ctrl_pkg::*;
#(
  parameter int BEATS = DEF_BEATS,
  parameter int WAYS  = DEF_WAYS,
  parameter int SETS  = DEF_SETS
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         valid_pre_i,
  output logic         ready_pre_o,
  input  logic [31:0]  miss_addr_i,
  input  logic         flush_i,
  output logic         arvalid_o,
  input  logic         arready_i,
  output logic [31:0]  araddr_o,
  output logic [7:0]   arlen_o,
  output logic [2:0]   arsize_o,
  output logic [1:0]   arburst_o,
  input  logic         rvalid_i,
  output logic         rready_o,
  input  logic [31:0]  rdata_i,
  input  logic [1:0]   rresp_i,
  input  logic         rlast_i,
  output logic         wen_o,
  output logic [2:0]   windex_o,
  output logic [2:0]   wway_o,
  output logic [24:0]  wtag_o,
  output logic [127:0] wdata_o,
  output logic         valid_post_o,
  input  logic         ready_post_i,
  output logic [127:0] block_o,
  output logic         err_o
);

  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  refill_state_e state_q, state_d;

  logic [31:0]  addr_q;
  logic [127:0] line_q;
  logic [1:0]   beat_q;
  logic         err_q;
  logic         kill_q;
  logic [2:0]   rr_way;

  logic accept;
  logic ar_hs;
  logic r_hs;
  logic last_beat;
  logic beat_bad;

  // A flush in IDLE must not slip a request past it.
  assign ready_pre_o = (state_q == ST_IDLE) && !flush_i;
  assign accept      = valid_pre_i && ready_pre_o;

  assign arvalid_o = (state_q == ST_ADDR);
  assign ar_hs     = arvalid_o && arready_i;
  assign rready_o  = (state_q == ST_DATA);
  assign r_hs      = rvalid_i && rready_o;

  assign last_beat = rlast_i || (beat_q == LAST_BEAT);
  assign beat_bad  = (rresp_i != AXI_RESP_OKAY) ||
                     (rlast_i != (beat_q == LAST_BEAT));

  assign araddr_o  = {addr_q[31:BLK_LSB], 4'h0};
  assign arlen_o   = arvalid_o ? 8'(BEATS - 1) : 8'd0;
  assign arsize_o  = arvalid_o ? AXI_SIZE_4B : 3'd0;
  assign arburst_o = arvalid_o ? AXI_BURST_INCR : 2'd0;

  assign wen_o    = (state_q == ST_WRITE) && !err_q;
  assign windex_o = addr_q[IDX_MSB:IDX_LSB];
  assign wtag_o   = addr_q[31:TAG_LSB];
  assign wway_o   = rr_way;
  assign wdata_o  = line_q;

  assign valid_post_o = (state_q == ST_DONE);
  assign block_o      = line_q;
  assign err_o        = err_q;

  icache_victim_rr #(
    .SETS(SETS),
    .WAYS(WAYS)
  ) u_rr (
    .clock  (clock),
    .reset  (reset),
    .index_i(windex_o),
    .inc_i  (wen_o),
    .way_o  (rr_way)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_ADDR;
      ST_ADDR:  if (ar_hs) state_d = ST_DATA;
      ST_DATA:  if (r_hs && last_beat) state_d = ST_WRITE;
      ST_WRITE: state_d = (flush_i || kill_q) ? ST_IDLE : ST_DONE;
      ST_DONE:  if (flush_i || ready_post_i) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      line_q  <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q <= miss_addr_i;
        line_q <= '0;
        beat_q <= '0;
        err_q  <= 1'b0;
        kill_q <= 1'b0;
      end
      // The burst is drained either way; the kill only drops the result.
      if (flush_i && (arvalid_o || rready_o)) begin
        kill_q <= 1'b1;
      end
      if (r_hs) begin
        line_q[{beat_q, 5'd0} +: 32] <= rdata_i;
        beat_q <= beat_q + 2'd1;
        if (beat_bad) err_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: directed and randomized refill scenarios
// checked against a line/victim-pointer reference model.
module tb_icache_refill_ctrl;

  logic         clock = 1'b0;
  logic         reset;
  logic         valid_pre_i;
  logic         ready_pre_o;
  logic [31:0]  miss_addr_i;
  logic         flush_i;
  logic         arvalid_o;
  logic         arready_i;
  logic [31:0]  araddr_o;
  logic [7:0]   arlen_o;
  logic [2:0]   arsize_o;
  logic [1:0]   arburst_o;
  logic         rvalid_i;
  logic         rready_o;
  logic [31:0]  rdata_i;
  logic [1:0]   rresp_i;
  logic         rlast_i;
  logic         wen_o;
  logic [2:0]   windex_o;
  logic [2:0]   wway_o;
  logic [24:0]  wtag_o;
  logic [127:0] wdata_o;
  logic         valid_post_o;
  logic         ready_post_i;
  logic [127:0] block_o;
  logic         err_o;

  icache_refill_ctrl dut (
    .clock(clock), .reset(reset),
    .valid_pre_i(valid_pre_i), .ready_pre_o(ready_pre_o),
    .miss_addr_i(miss_addr_i), .flush_i(flush_i),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arsize_o(arsize_o), .arburst_o(arburst_o),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .wen_o(wen_o), .windex_o(windex_o), .wway_o(wway_o),
    .wtag_o(wtag_o), .wdata_o(wdata_o),
    .valid_post_o(valid_post_o), .ready_post_i(ready_post_i),
    .block_o(block_o), .err_o(err_o)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: victim pointer per set, plus the beats being sent
  int          ref_ptr [8];
  logic [31:0] beat_data [4];
  logic [1:0]  beat_resp [4];

  // observations gathered by the refill driver
  logic         obs_rdy_pre, obs_arv, obs_rdy_after, obs_err;
  logic [31:0]  obs_araddr;
  logic [7:0]   obs_arlen;
  logic [2:0]   obs_arsize;
  logic [1:0]   obs_arburst;
  logic [2:0]   obs_wway, obs_windex;
  logic [24:0]  obs_wtag;
  logic [127:0] obs_wdata, obs_blk;
  int obs_wen, obs_k_wen, obs_lat, obs_vcnt, obs_beats;
  int obs_ar_bad, obs_blk_bad, obs_to;

  function automatic logic [127:0] exp_line();
    logic [127:0] l;
    for (int b = 0; b < 4; b++) l[32*b +: 32] = beat_data[b];
    return l;
  endfunction

  function automatic logic [31:0] mk_addr(input int idx);
    logic [31:0] a;
    a = $urandom;
    a[6:4] = 3'(idx);
    return a;
  endfunction

  task automatic fill_beats();
    for (int b = 0; b < 4; b++) begin
      beat_data[b] = $urandom;
      beat_resp[b] = 2'd0;
    end
  endtask

  task automatic idle_inputs();
    valid_pre_i = 0; miss_addr_i = '0; flush_i = 0;
    arready_i = 0; rvalid_i = 0; rdata_i = '0;
    rresp_i = 0; rlast_i = 0; ready_post_i = 0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1;
    @(negedge clock);
    reset = 0;
    for (int i = 0; i < 8; i++) ref_ptr[i] = 0;
  endtask

  // rl_beat: beat carrying rlast (4 = none); flush_beat: -1 none, -2 ADDR
  task automatic refill(input logic [31:0] addr, input int ar_wait,
                        input int rl_beat, input int flush_beat,
                        input int post_wait);
    int n, nb;
    obs_wen = 0; obs_k_wen = -1; obs_lat = -1; obs_vcnt = 0;
    obs_beats = 0; obs_ar_bad = 0; obs_blk_bad = 0; obs_to = 0;
    obs_err = 0; obs_blk = '0;
    nb = (rl_beat < 3) ? rl_beat + 1 : 4;
    @(negedge clock);
    valid_pre_i = 1; miss_addr_i = addr;
    #1 obs_rdy_pre = ready_pre_o;
    @(negedge clock);
    valid_pre_i = 0; miss_addr_i = $urandom;
    for (int i = 0; i <= ar_wait; i++) begin
      if (i > 0) @(negedge clock);
      arready_i = (i == ar_wait);
      flush_i = (flush_beat == -2) && (i == 0);
      #1;
      if (i == 0) begin
        obs_arv = arvalid_o; obs_araddr = araddr_o;
        obs_arlen = arlen_o; obs_arsize = arsize_o;
        obs_arburst = arburst_o;
      end else if (arvalid_o !== 1'b1 || araddr_o !== obs_araddr) begin
        obs_ar_bad++;
      end
    end
    for (int b = 0; b < nb; b++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clock);
        arready_i = 0; flush_i = 0; rvalid_i = 0; rlast_i = 0;
      end
      @(negedge clock);
      arready_i = 0;
      rvalid_i = 1; rdata_i = beat_data[b]; rresp_i = beat_resp[b];
      rlast_i = (b == rl_beat); flush_i = (b == flush_beat);
      #1 n = 0;
      while (!rready_o && n < 8) begin
        @(negedge clock);
        flush_i = 0;
        #1 n++;
      end
      if (rready_o) obs_beats++;
      else obs_to++;
    end
    for (int k = 1; k <= post_wait + 6; k++) begin
      @(negedge clock);
      idle_inputs();
      #1;
      if (wen_o) begin
        obs_wen++; obs_k_wen = k; obs_wway = wway_o;
        obs_windex = windex_o; obs_wtag = wtag_o; obs_wdata = wdata_o;
      end
      if (valid_post_o) begin
        obs_vcnt++;
        if (obs_lat < 0) begin
          obs_lat = k; obs_blk = block_o; obs_err = err_o;
        end else if (block_o !== obs_blk || err_o !== obs_err) begin
          obs_blk_bad++;
        end
        if (k - obs_lat >= post_wait) ready_post_i = 1;
      end
    end
    @(negedge clock);
    idle_inputs();
    #1 obs_rdy_after = ready_pre_o;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++;
    if (ready_pre_o !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready_pre: got %b want 1", ready_pre_o);
    end
    n_cmp++;
    if ({arvalid_o, rready_o, wen_o, valid_post_o, err_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 00000",
               {arvalid_o, rready_o, wen_o, valid_post_o, err_o});
    end
    n_cmp++;
    if ({araddr_o, arlen_o, wway_o, windex_o, wtag_o} !== '0 ||
        block_o !== '0 || wdata_o !== '0) begin
      n_bad++;
      $display("FAIL reset_data: araddr %h block %h want 0",
               araddr_o, block_o);
    end
  endtask

  task automatic test_single();
    beat_data[0] = 32'h11; beat_data[1] = 32'h22;
    beat_data[2] = 32'h33; beat_data[3] = 32'h44;
    for (int b = 0; b < 4; b++) beat_resp[b] = 0;
    refill(32'h8000_0124, 0, 3, -1, 0);
    n_cmp++;
    if (obs_rdy_pre !== 1'b1 || obs_arv !== 1'b1) begin
      n_bad++;
      $display("FAIL single_hs: ready %b arvalid %b want 1 1",
               obs_rdy_pre, obs_arv);
    end
    n_cmp++;
    if (obs_araddr !== 32'h8000_0120) begin
      n_bad++; $display("FAIL single_araddr: got %h want 80000120", obs_araddr);
    end
    n_cmp++;
    if ({obs_arlen, obs_arsize, obs_arburst} !== {8'd3, 3'd2, 2'b01}) begin
      n_bad++;
      $display("FAIL single_arattr: got len %0d size %0d burst %0d want 3 2 1",
               obs_arlen, obs_arsize, obs_arburst);
    end
    n_cmp++;
    if (obs_wen !== 1 || obs_k_wen !== 1) begin
      n_bad++;
      $display("FAIL single_wen: got %0d pulses at %0d want 1 at 1",
               obs_wen, obs_k_wen);
    end
    n_cmp++;
    if ({obs_windex, obs_wtag, obs_wway} !== {3'd2, 25'h1000002, 3'd0}) begin
      n_bad++;
      $display("FAIL single_wfields: idx %0d tag %h way %0d want 2 1000002 0",
               obs_windex, obs_wtag, obs_wway);
    end
    n_cmp++;
    if (obs_wdata !== 128'h00000044_00000033_00000022_00000011) begin
      n_bad++; $display("FAIL single_wdata: got %h want %h", obs_wdata,
                        128'h00000044_00000033_00000022_00000011);
    end
    n_cmp++;
    if (obs_lat !== 2 || obs_err !== 1'b0) begin
      n_bad++;
      $display("FAIL single_post: lat %0d err %b want 2 0", obs_lat, obs_err);
    end
    n_cmp++;
    if (obs_blk !== exp_line() || obs_rdy_after !== 1'b1) begin
      n_bad++;
      $display("FAIL single_block: got %h rdy %b want %h 1",
               obs_blk, obs_rdy_after, exp_line());
    end
    ref_ptr[2] = (ref_ptr[2] + 1) % 8;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      fill_beats();
      refill(mk_addr(2), 0, 3, -1, 0);
      n_cmp++;
      if (obs_wen !== 1 || obs_wway !== 3'(i % 8)) begin
        n_bad++;
        $display("FAIL rr_way[%0d]: got %0d (wen %0d) want %0d",
                 i, obs_wway, obs_wen, i % 8);
      end
      ref_ptr[2] = (ref_ptr[2] + 1) % 8;
    end
    fill_beats();
    refill(mk_addr(3), 0, 3, -1, 0);
    n_cmp++;
    if (obs_wen !== 1 || obs_wway !== 3'd0) begin
      n_bad++; $display("FAIL rr_idx3: got %0d want 0", obs_wway);
    end
    ref_ptr[3] = (ref_ptr[3] + 1) % 8;
  endtask

  task automatic test_error();
    fill_beats();
    beat_resp[1] = 2'd2;
    refill(mk_addr(2), 0, 3, -1, 0);
    n_cmp++;
    if (obs_wen !== 0) begin
      n_bad++; $display("FAIL err_wen: got %0d pulses want 0", obs_wen);
    end
    n_cmp++;
    if (obs_vcnt !== 1 || obs_err !== 1'b1) begin
      n_bad++;
      $display("FAIL err_done: valid %0d err %b want 1 1", obs_vcnt, obs_err);
    end
    fill_beats();
    refill(mk_addr(2), 0, 3, -1, 0);
    n_cmp++;
    if (obs_wway !== 3'(ref_ptr[2])) begin
      n_bad++;
      $display("FAIL err_ptr: got %0d want %0d", obs_wway, ref_ptr[2]);
    end
    ref_ptr[2] = (ref_ptr[2] + 1) % 8;
  endtask

  task automatic test_flush();
    fill_beats();
    refill(mk_addr(6), 1, 3, 0, 0);
    n_cmp++;
    if (obs_beats !== 4 || obs_to !== 0) begin
      n_bad++;
      $display("FAIL flush_beats: got %0d want 4", obs_beats);
    end
    n_cmp++;
    if (obs_wen !== 1 || obs_wway !== 3'(ref_ptr[6])) begin
      n_bad++;
      $display("FAIL flush_wen: pulses %0d way %0d want 1 %0d",
               obs_wen, obs_wway, ref_ptr[6]);
    end
    n_cmp++;
    if (obs_vcnt !== 0 || obs_rdy_after !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_post: valid %0d rdy %b want 0 1",
               obs_vcnt, obs_rdy_after);
    end
    ref_ptr[6] = (ref_ptr[6] + 1) % 8;
  endtask

  task automatic test_backpressure();
    fill_beats();
    refill(mk_addr(1), 5, 3, -1, 3);
    n_cmp++;
    if (obs_arv !== 1'b1 || obs_ar_bad !== 0) begin
      n_bad++;
      $display("FAIL bp_ar: arvalid %b unstable %0d want 1 0",
               obs_arv, obs_ar_bad);
    end
    n_cmp++;
    if (obs_vcnt !== 4 || obs_blk_bad !== 0 || obs_blk !== exp_line()) begin
      n_bad++;
      $display("FAIL bp_post: valid %0d unstable %0d blk %h want 4 0 %h",
               obs_vcnt, obs_blk_bad, obs_blk, exp_line());
    end
    ref_ptr[1] = (ref_ptr[1] + 1) % 8;
  endtask

  task automatic test_reset_mid();
    fill_beats();
    refill(mk_addr(5), 0, 3, -1, 0);
    ref_ptr[5] = (ref_ptr[5] + 1) % 8;
    @(negedge clock);
    valid_pre_i = 1; miss_addr_i = mk_addr(5);
    @(negedge clock);
    valid_pre_i = 0; arready_i = 1;
    @(negedge clock);
    arready_i = 0; rvalid_i = 1; rdata_i = $urandom; rresp_i = 0;
    @(negedge clock);
    rdata_i = $urandom;
    @(negedge clock);
    reset = 1;
    @(negedge clock);
    reset = 0;
    idle_inputs();
    for (int i = 0; i < 8; i++) ref_ptr[i] = 0;
    #1;
    n_cmp++;
    if (ready_pre_o !== 1'b1 ||
        {arvalid_o, rready_o, wen_o, valid_post_o, err_o} !== 5'b0) begin
      n_bad++;
      $display("FAIL rmid_ctrl: rdy %b ctrl %b want 1 00000", ready_pre_o,
               {arvalid_o, rready_o, wen_o, valid_post_o, err_o});
    end
    n_cmp++;
    if ({araddr_o, windex_o, wtag_o, wway_o} !== '0 || block_o !== '0) begin
      n_bad++;
      $display("FAIL rmid_data: araddr %h block %h want 0", araddr_o, block_o);
    end
    fill_beats();
    refill(mk_addr(5), 0, 3, -1, 0);
    n_cmp++;
    if (obs_wen !== 1 || obs_wway !== 3'd0) begin
      n_bad++; $display("FAIL rmid_ptr: got %0d want 0", obs_wway);
    end
    ref_ptr[5] = 1;
  endtask

  task automatic test_random();
    logic [31:0] a;
    int idx, rl, fb, nb, flushed;
    logic e;
    for (int t = 0; t < 24; t++) begin
      fill_beats();
      a = $urandom;
      idx = int'(a[6:4]);
      rl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4) : 3;
      nb = (rl < 3) ? rl + 1 : 4;
      if ($urandom_range(0, 5) == 0) beat_resp[$urandom_range(0, nb - 1)] =
        2'($urandom_range(1, 3));
      fb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, nb + 1) - 2 : -1;
      flushed = (fb != -1) ? 1 : 0;
      e = (rl != 3);
      for (int b = 0; b < nb; b++) if (beat_resp[b] != 0) e = 1;
      refill(a, $urandom_range(0, 3), rl, fb, $urandom_range(0, 3));
      n_cmp++;
      if (obs_wen !== (e ? 0 : 1) || obs_beats !== nb) begin
        n_bad++;
        $display("FAIL rnd_wen[%0d]: pulses %0d beats %0d want %0d %0d",
                 t, obs_wen, obs_beats, e ? 0 : 1, nb);
      end
      if (!e) begin
        n_cmp++;
        if (obs_wway !== 3'(ref_ptr[idx]) || obs_windex !== a[6:4] ||
            obs_wtag !== a[31:7] || obs_wdata !== exp_line()) begin
          n_bad++;
          $display("FAIL rnd_write[%0d]: way %0d idx %0d want %0d %0d",
                   t, obs_wway, obs_windex, ref_ptr[idx], idx);
        end
        ref_ptr[idx] = (ref_ptr[idx] + 1) % 8;
      end
      n_cmp++;
      if (flushed != 0 && obs_vcnt !== 0) begin
        n_bad++; $display("FAIL rnd_kill[%0d]: valid %0d want 0", t, obs_vcnt);
      end else if (flushed == 0 && (obs_lat !== 2 || obs_err !== e ||
                   obs_blk_bad !== 0 || (!e && obs_blk !== exp_line()))) begin
        n_bad++;
        $display("FAIL rnd_post[%0d]: lat %0d err %b want 2 %b",
                 t, obs_lat, obs_err, e);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1;
    idle_inputs();
    repeat (2) @(negedge clock);
    test_reset();
    test_single();
    test_round_robin();
    test_error();
    test_flush();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/icache_refill_ctrl.md
ICACHE_REFILL_CTRL -- requirements
Module: icache_refill_ctrl

Interface
REQ-001 SHALL use one clock and a synchronous, active-high reset: ports clock and reset.
REQ-002 SHALL have these ports, in this order (name, direction, width, meaning):
  - clock  in  1  system clock
  - reset  in  1  synchronous active-high reset
  - valid_pre_i  in  1  miss request valid
  - ready_pre_o  out  1  request accepted
  - miss_addr_i  in  32  missing fetch address
  - flush_i  in  1  pipeline flush
  - arvalid_o  out  1  AXI read-address valid
  - arready_i  in  1  AXI read-address ready
  - araddr_o  out  32  block-aligned address
  - arlen_o  out  8  burst length
  - arsize_o  out  3  beat size
  - arburst_o  out  2  burst type
  - rvalid_i  in  1  AXI read-data valid
  - rready_o  out  1  AXI read-data ready
  - rdata_i  in  32  read beat
  - rresp_i  in  2  beat response
  - rlast_i  in  1  last beat
  - wen_o  out  1  cache line write strobe
  - windex_o  out  3  set index
  - wway_o  out  3  victim way
  - wtag_o  out  25  line tag
  - wdata_o  out  128  line data
  - valid_post_o  out  1  refill result valid
  - ready_post_i  in  1  result consumed
  - block_o  out  128  refilled line
  - err_o  out  1  bus error on refill
REQ-003 SHALL use these parameters (name, default, meaning): BEATS = 4, beats per line; WAYS = 8, ways per set; SETS = 8, number of sets.

Function
REQ-004 SHALL decode the latched address as: index = addr[6:4], tag = addr[31:7], burst address = {addr[31:4], 4'h0}.
REQ-005 SHALL implement the state machine IDLE -> ADDR -> DATA -> WRITE -> DONE -> IDLE.
REQ-006 SHALL drive ready_pre_o = 1 only in IDLE, and latch miss_addr_i when valid_pre_i && ready_pre_o, then enter ADDR.
REQ-007 SHALL, in ADDR, hold arvalid_o = 1 with arlen_o = 3, arsize_o = 2, arburst_o = 2'b01 (INCR), and enter DATA when arvalid_o && arready_i.
REQ-008 SHALL, in DATA, drive rready_o = 1, place beat k at buffer[32k+31:32k], and advance a 2-bit beat counter on each rvalid_i && rready_o.
REQ-009 SHALL leave DATA on the beat where rlast_i = 1 or the counter reaches 3, whichever comes first.
REQ-010 SHALL set a sticky error flag when any beat has rresp_i != 0, or when rlast_i does not coincide with beat 3.
REQ-011 SHALL, in WRITE, pulse wen_o for exactly one cycle with the latched index/tag, the current round-robin way and the assembled line, suppressing the pulse when the error flag is set; WRITE always lasts one cycle.
REQ-012 SHALL keep one 3-bit round-robin victim pointer per set, incremented modulo 8 only on a performed write (7 wraps to 0).
REQ-013 SHALL, in DONE, hold valid_post_o = 1 with block_o and err_o stable until ready_post_i, then return to IDLE; valid_post_o and ready_post_i both high in the same cycle completes the transfer in that cycle.
REQ-014 SHALL, when flush_i is asserted in IDLE, DONE or WRITE, return to IDLE next cycle; a WRITE-cycle wen_o still occurs.
REQ-015 SHALL, when flush_i is asserted in ADDR or DATA, set a kill flag and finish the AXI transaction (no abandoned burst), perform the WRITE normally, then skip DONE and go to IDLE.
REQ-016 SHALL give a latency of 1 cycle from acceptance to arvalid_o, and exactly 2 cycles from the last beat to valid_post_o (WRITE, then DONE).
REQ-017 SHALL hold wen_o = 0 at all times outside WRITE.

Reset
REQ-018 SHALL, on reset, set the state to IDLE, all outputs, the beat counter and the error/kill flags to 0, and all round-robin pointers to 0, overriding any in-flight burst.

Structure
REQ-019 SHALL place the shared package constants there: state encodings, BEATS/WAYS/SETS, the index/tag bit positions and the AXI burst constants; the cache-access stage uses the same constants.
REQ-020 SHALL keep the round-robin victim pointers in one sub-module, icache_victim_rr (per-set read by index, increment on write).

Verification
REQ-021 Single refill: miss 0x8000_0124, arready immediate, beats 11,22,33,44 with rlast on beat 4 -> araddr_o 0x8000_0120, wen_o pulses once with windex_o 2, wtag_o 0x1000002, wway_o 0, wdata_o 0x00000044_00000033_00000022_00000011, and valid_post_o two cycles after the last beat.
REQ-022 Round-robin: nine refills to index 2 -> wway_o 0..7 then 0; index 3 pointer stays 0.
REQ-023 Error: rresp_i = 2 on beat 2 -> no wen_o pulse, err_o = 1 in DONE, pointer unchanged.
REQ-024 Flush on beat 1 -> all 4 beats still accepted, wen_o pulses, valid_post_o never rises, ready_pre_o = 1 afterwards.
REQ-025 Backpressure: arready_i held low 5 cycles, then ready_post_i low 3 cycles -> arvalid_o/araddr_o stable throughout, and block_o stable while valid_post_o is high.
REQ-026 Reset asserted mid-DATA -> IDLE next cycle, all outputs 0, pointers 0.
